// File: rtl/pulse_stretch_if.sv
// Strobe-in / stretched-pulse-out bundle for pulse_stretch.
// The master side is the control logic issuing strobes; the slave side is
// the stretcher that drives the pin-level pulse and its status.
interface pulse_stretch_if #(
  parameter int PEND_W = 2
) ();
  logic              stb_i;
  logic              clr_ovf_i;
  logic              pulse_o;
  logic              busy_o;
  logic [PEND_W-1:0] pend_o;
  logic              ovf_o;

  modport master (
    output stb_i,
    output clr_ovf_i,
    input  pulse_o,
    input  busy_o,
    input  pend_o,
    input  ovf_o
  );

  modport slave (
    input  stb_i,
    input  clr_ovf_i,
    output pulse_o,
    output busy_o,
    output pend_o,
    output ovf_o
  );
endinterface

// File: rtl/pulse_stretch.sv
// Turns single-cycle strobes into fixed-width level pulses separated by a
// mandatory low gap. Strobes arriving while a pulse or gap is running are
// queued in a saturating counter and replayed back to back, so every strobe
// yields its own pulse unless the queue overflows (flagged, sticky).
module pulse_stretch #(
  parameter int PULSE_LEN = 8,
  parameter int GAP_LEN   = 2,
  parameter int PEND_W    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pulse_stretch_if.slave   bus
);

  // The down-counter must hold the longer of the two phase lengths.
  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_FULL  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              start_direct;
  logic              consume;
  logic              pend_inc;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_set;
  logic              ovf_nxt;

  // Saturating pending-count update. Returns {overflow, new count}.
  // A simultaneous increment and decrement cancel, so a strobe landing on
  // the consuming cycle neither changes the count nor overflows it.
  function automatic logic [PEND_W:0] pend_update(
    input logic [PEND_W-1:0] pend,
    input logic              inc,
    input logic              dec
  );
    logic [PEND_W:0] res;
    res = {1'b0, pend};
    if (inc && !dec) begin
      if (pend == PEND_FULL) begin
        res = {1'b1, pend};
      end else begin
        res = {1'b0, pend + PEND_ONE};
      end
    end else if (dec && !inc) begin
      res = {1'b0, pend - PEND_ONE};
    end
    return res;
  endfunction

  // Sticky overflow flag: a new overflow beats a clear in the same cycle.
  function automatic logic ovf_update(
    input logic ovf,
    input logic set,
    input logic clr
  );
    logic res;
    if (set) begin
      res = 1'b1;
    end else if (clr) begin
      res = 1'b0;
    end else begin
      res = ovf;
    end
    return res;
  endfunction

  // Next-state and counter logic; also flags how a new pulse was started.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    start_direct = 1'b0;
    consume      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.stb_i) begin
          state_nxt    = HIGH;
          cnt_nxt      = PULSE_LOAD;
          start_direct = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (bus.pend_o != '0) begin
          // Queued requests are served before a fresh strobe; the fresh
          // strobe is then queued behind them.
          state_nxt = HIGH;
          cnt_nxt   = PULSE_LOAD;
          consume   = 1'b1;
        end else if (bus.stb_i) begin
          state_nxt    = HIGH;
          cnt_nxt      = PULSE_LOAD;
          start_direct = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Queue and overflow bookkeeping for strobes that could not start a pulse.
  always_comb begin
    pend_inc            = bus.stb_i && !start_direct;
    {ovf_set, pend_nxt} = pend_update(bus.pend_o, pend_inc, consume);
    ovf_nxt             = ovf_update(bus.ovf_o, ovf_set, bus.clr_ovf_i);
  end

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.pulse_o <= 1'b0;
      bus.busy_o  <= 1'b0;
      bus.pend_o  <= '0;
      bus.ovf_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bus.pulse_o <= (state_nxt == HIGH);
      bus.busy_o  <= (state_nxt != IDLE);
      bus.pend_o  <= pend_nxt;
      bus.ovf_o   <= ovf_nxt;
    end
  end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Converts single-cycle strobes (such as the debounced button strobe from the input oneshot) back into visible, fixed-width level pulses for LEDs, buzzers or external handshakes. Each accepted strobe produces exactly one high pulse of `PULSE_LEN` cycles, followed by a mandatory low gap of `GAP_LEN` cycles. Strobes that arrive while a pulse or gap is in progress are counted in a saturating pending counter and replayed in order, so no strobe is silently merged. The block sits on the output side of the user-I/O path, between the control logic and the pin drivers.

## Interface
Parameters:
- `PULSE_LEN`, default 8: high time of each output pulse, in clock cycles; must be ≥ 1.
- `GAP_LEN`, default 2: minimum low time between consecutive pulses, in cycles; must be ≥ 1.
- `PEND_W`, default 2: width of the pending counter; at most 2^`PEND_W`−1 strobes can be queued.

Ports:
- `clk_i`  in  1  single clock; all state changes on its rising edge.
- `rst_i`  in  1  reset; **asynchronous, active-high**.
- `stb_i`  in  1  request strobe, sampled every cycle; each high sample counts as one request.
- `clr_ovf_i`  in  1  clears the sticky overflow flag.
- `pulse_o`  out  1  stretched pulse, registered.
- `busy_o`  out  1  high while the FSM is not in IDLE, registered.
- `pend_o`  out  `PEND_W`  number of queued requests.
- `ovf_o`  out  1  sticky flag: a request was dropped because the pending counter was full.

## Operation
- FSM states: IDLE, HIGH, GAP. A down-counter `cnt` is sized to hold max(`PULSE_LEN`, `GAP_LEN`).
- IDLE:
  - `stb_i`=1 → go to HIGH and load `cnt`=`PULSE_LEN`−1.
  - Otherwise stay in IDLE.
  - `pend_o` is always 0 in IDLE.
- HIGH:
  - `pulse_o`=1.
  - When `cnt`=0 → go to GAP and load `cnt`=`GAP_LEN`−1; otherwise decrement `cnt`.
- GAP:
  - `pulse_o`=0.
  - When `cnt`≠0, decrement `cnt`.
  - When `cnt`=0 and (`pend_o`>0 or `stb_i`=1) → go to HIGH and load `cnt`=`PULSE_LEN`−1.
  - When `cnt`=0 and there is no request → go to IDLE.
- Pending counter update, evaluated each cycle:
  - Increment when `stb_i`=1 and the strobe does not directly start a pulse.
  - Decrement when a pulse starts from GAP with `pend_o`>0.
  - `stb_i` arriving on the consuming cycle with `pend_o`>0: increment and decrement cancel, so `pend_o` is unchanged.
  - `stb_i` arriving on the last GAP cycle with `pend_o`=0: starts the pulse directly and does not increment.
- Saturation: an increment at `pend_o`=2^`PEND_W`−1 with no simultaneous decrement leaves `pend_o` unchanged and sets `ovf_o`.
- `ovf_o` is sticky. It is cleared by `clr_ovf_i`=1. If a set and a clear occur in the same cycle, set wins.
- `busy_o` = (state ≠ IDLE), registered together with the state.
- Reset (asynchronous, at any time, including mid-pulse):
  - State → IDLE, `cnt` → 0.
  - `pulse_o`, `busy_o`, `pend_o`, `ovf_o` all → 0 immediately, with no clock edge required.
  - No queued request survives reset.

## Timing
- Latency: a strobe sampled at edge E0 in IDLE gives `pulse_o`=1 after E0 through edge E(`PULSE_LEN`), then `pulse_o`=0 for `GAP_LEN` cycles.
- Minimum pulse-to-pulse period is `PULSE_LEN`+`GAP_LEN` cycles. Back-to-back queued pulses achieve exactly this period.
- `busy_o` is high for `PULSE_LEN`+`GAP_LEN` cycles per isolated pulse.
- `pend_o` and `ovf_o` update on the same edge that samples `stb_i`.
- `stb_i` held high for N cycles counts as N requests; upstream is expected to deliver single-cycle strobes.

## Test plan
Settings for all scenarios: `PULSE_LEN`=4, `GAP_LEN`=2, `PEND_W`=2.
1. Assert `rst_i`, then release with no strobes → `pulse_o`=`busy_o`=`ovf_o`=0 and `pend_o`=0 for 20 cycles.
2. Single strobe at E0 → `pulse_o`=1 after E0..E4, `busy_o`=1 after E0..E6, then IDLE.
3. Strobes at E0 and E2 → `pend_o`=1 after E2. At E6 the queued request is consumed: `pend_o`=0 and the second pulse is high after E6..E10.
4. Strobe at E6 only, as a second isolated request (first strobe at E0) → second pulse is high after E6..E10 and `pend_o` stays 0 throughout.
5. Four strobes at E1..E4 (first strobe at E0) → `pend_o` saturates at 3 after E3, `ovf_o`=1 after E4. Three more pulses follow at 6-cycle period. `ovf_o` stays 1 until `clr_ovf_i`; a `clr_ovf_i` coinciding with an overflowing strobe leaves `ovf_o`=1.
6. Assert `rst_i` asynchronously mid-HIGH with `pend_o`=2 and `ovf_o`=1 → all outputs 0 before the next clock edge. After release, a new strobe gives exactly one 4-cycle pulse.
